// File: rtl/cache2vias_ctrl.sv
// Sequencing controller for a 2-way set-associative, write-back / write-allocate cache
// with 1-bit LRU per set, a single-word line, and saturating hit/miss statistics.
module cache2vias_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic              cpu_hit,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int SETS  = 2 ** IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;

    state_t state, state_nxt;

    logic              req_wren;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic [1:0][SETS-1:0] valid_q;
    logic [1:0][SETS-1:0] dirty_q;
    logic [SETS-1:0]      lru_q;
    logic [TAG_W-1:0]     tag_mem  [2][SETS];
    logic [DATA_W-1:0]    data_mem [2][SETS];
    logic                 victim_q;

    logic [IDX_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;
    logic              hit0, hit1, hit, hit_way;
    logic              lookup_victim;
    logic [DATA_W-1:0] fill_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign req_set   = req_addr[IDX_W-1:0];
    assign req_tag   = req_addr[ADDR_W-1:IDX_W];
    assign hit0      = valid_q[0][req_set] && (tag_mem[0][req_set] == req_tag);
    assign hit1      = valid_q[1][req_set] && (tag_mem[1][req_set] == req_tag);
    assign hit       = hit0 || hit1;
    assign hit_way   = hit1;
    assign fill_data = req_wren ? req_wdata : mem_rdata;

    // Prefer an empty way (way 0 first); only evict by LRU when the set is full.
    assign lookup_victim = !valid_q[0][req_set] ? 1'b0 :
                           !valid_q[1][req_set] ? 1'b1 : lru_q[req_set];

    always_comb begin
        state_nxt = state;
        cpu_ready = 1'b0;
        cpu_done  = 1'b0;
        mem_req   = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit)
                    state_nxt = RESP;
                else if (valid_q[lookup_victim][req_set] && dirty_q[lookup_victim][req_set])
                    state_nxt = WB;
                else
                    state_nxt = FILL;
            end
            WB: begin
                mem_req   = 1'b1;
                mem_wren  = 1'b1;
                mem_addr  = {tag_mem[victim_q][req_set], req_set};
                mem_wdata = data_mem[victim_q][req_set];
                if (mem_ack) state_nxt = FILL;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = req_addr;
                if (mem_ack) state_nxt = RESP;
            end
            RESP: begin
                cpu_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            valid_q   <= '0;
            dirty_q   <= '0;
            lru_q     <= '0;
            victim_q  <= 1'b0;
            cpu_hit   <= 1'b0;
            cpu_rdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == LOOKUP) begin
                if (hit) begin
                    cpu_hit        <= 1'b1;
                    cpu_rdata      <= req_wren ? req_wdata : data_mem[hit_way][req_set];
                    lru_q[req_set] <= ~hit_way;
                    hit_cnt        <= sat_inc(hit_cnt);
                    if (req_wren) dirty_q[hit_way][req_set] <= 1'b1;
                end else begin
                    cpu_hit  <= 1'b0;
                    victim_q <= lookup_victim;
                    miss_cnt <= sat_inc(miss_cnt);
                end
            end
            if (state == FILL && mem_ack) begin
                valid_q[victim_q][req_set] <= 1'b1;
                dirty_q[victim_q][req_set] <= req_wren;
                lru_q[req_set]             <= ~victim_q;
                cpu_rdata                  <= fill_data;
            end
        end
    end

    // Request latch and line storage carry no reset; validity is tracked by valid_q.
    always_ff @(posedge clock) begin
        if (state == IDLE && cpu_req) begin
            req_wren  <= cpu_wren;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
        end
        if (state == LOOKUP && hit && req_wren)
            data_mem[hit_way][req_set] <= req_wdata;
        if (state == FILL && mem_ack) begin
            tag_mem[victim_q][req_set]  <= req_tag;
            data_mem[victim_q][req_set] <= fill_data;
        end
    end

endmodule
